// File: rtl/visor_dbg_pkg.sv
// Shared types and constants for the visor debug-port register-peek sequencer.
package visor_dbg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DIVERT,
        LOAD_PEEK,
        EXEC,
        CAPTURE,
        RESTORE,
        UNHOLD,
        RELEASE
    } state_e;

    // tg_force bit positions: {force_exec, force_load_exr, hold_state}
    localparam logic [2:0] HOLD_STATE_MASK     = 3'd1;
    localparam logic [2:0] FORCE_LOAD_EXR_MASK = 3'd2;
    localparam logic [2:0] FORCE_EXEC_MASK     = 3'd4;

    // bus_ctrl bit positions on the target debug port
    localparam logic [7:0] DIVERT_CODE_BUS_MASK = 8'd4;
    localparam logic [7:0] TG_RESET_MASK        = 8'd2;

    localparam logic [15:0] PEEK_OPCODE_BASE_DEFAULT = 16'h7c00;

    function automatic logic [15:0] peek_opcode(input logic [15:0] base, input logic [3:0] sel);
        return base | {12'd0, sel};
    endfunction

endpackage

// File: rtl/dbg_step_timer.sv
// Loadable 4-bit down counter timing each sequencer step; zero_o marks the step's last cycle.
module dbg_step_timer (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       load_i,
    input  logic [3:0] load_val_i,
    output logic       zero_o
);

    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == 4'd0);

endmodule

// File: rtl/dbg_peek_sequencer.sv
// Sequences divert/hold, forced peek-opcode load+exec, capture, and exr restore on a halted target.
module dbg_peek_sequencer
    import visor_dbg_pkg::*;
#(
    parameter logic [15:0] PEEK_OPCODE_BASE = PEEK_OPCODE_BASE_DEFAULT,
    parameter int          SETTLE_CYCLES    = 2,
    parameter int          CAPTURE_DELAY    = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req,
    input  logic [3:0]  reg_sel,
    input  logic        tg_halted,
    input  logic [15:0] exr_shadow,
    input  logic [15:0] peek_data,
    output logic        divert_code_bus,
    output logic [2:0]  tg_force,
    output logic [15:0] force_opcode,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] result
);

    localparam logic [3:0] SETTLE_LD  = 4'(SETTLE_CYCLES - 1);
    localparam logic [3:0] CAPTURE_LD = (CAPTURE_DELAY == 0) ? 4'd0 : 4'(CAPTURE_DELAY - 1);

    state_e      state_q, state_d;
    logic [3:0]  sel_q, sel_d;
    logic [15:0] shadow_q, shadow_d;
    logic        divert_q, divert_d;
    logic [2:0]  tg_force_q, tg_force_d;
    logic [15:0] opcode_q, opcode_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [15:0] result_q, result_d;

    logic        step_load;
    logic [3:0]  step_ld_val;
    logic        step_zero;

    dbg_step_timer u_step_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_i     (step_load),
        .load_val_i (step_ld_val),
        .zero_o     (step_zero)
    );

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        shadow_d    = shadow_q;
        result_d    = result_q;
        err_d       = 1'b0;
        divert_d    = 1'b0;
        tg_force_d  = 3'b000;
        opcode_d    = opcode_q;
        done_d      = 1'b0;
        step_ld_val = 4'd0;

        case (state_q)
            IDLE: begin
                if (req) begin
                    if (tg_halted) begin
                        state_d  = DIVERT;
                        sel_d    = reg_sel;
                        shadow_d = exr_shadow;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            DIVERT:    if (step_zero) state_d = LOAD_PEEK;
            LOAD_PEEK: if (step_zero) state_d = EXEC;
            EXEC:      if (step_zero) state_d = CAPTURE;
            CAPTURE: begin
                if (step_zero) begin
                    result_d = peek_data;
                    state_d  = RESTORE;
                end
            end
            RESTORE:   if (step_zero) state_d = UNHOLD;
            UNHOLD:    state_d = RELEASE;
            RELEASE:   state_d = IDLE;
            default:   state_d = IDLE;
        endcase

        // Outputs are registered from the next state so they change on the same edge as the state.
        case (state_d)
            IDLE: opcode_d = 16'd0;
            DIVERT: begin
                divert_d    = 1'b1;
                tg_force_d  = HOLD_STATE_MASK;
                step_ld_val = SETTLE_LD;
            end
            LOAD_PEEK: begin
                divert_d    = 1'b1;
                tg_force_d  = HOLD_STATE_MASK | FORCE_LOAD_EXR_MASK;
                opcode_d    = peek_opcode(PEEK_OPCODE_BASE, sel_d);
                step_ld_val = SETTLE_LD;
            end
            EXEC: begin
                divert_d    = 1'b1;
                tg_force_d  = HOLD_STATE_MASK | FORCE_EXEC_MASK;
                step_ld_val = SETTLE_LD;
            end
            CAPTURE: begin
                divert_d    = 1'b1;
                tg_force_d  = HOLD_STATE_MASK;
                step_ld_val = CAPTURE_LD;
            end
            RESTORE: begin
                divert_d    = 1'b1;
                tg_force_d  = HOLD_STATE_MASK | FORCE_LOAD_EXR_MASK;
                opcode_d    = shadow_d;
                step_ld_val = SETTLE_LD;
            end
            UNHOLD: divert_d = 1'b1;
            RELEASE: begin
                opcode_d = 16'd0;
                done_d   = 1'b1;
            end
            default: opcode_d = 16'd0;
        endcase

        busy_d    = (state_d != IDLE);
        step_load = (state_d != state_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            sel_q      <= 4'd0;
            shadow_q   <= 16'd0;
            divert_q   <= 1'b0;
            tg_force_q <= 3'b000;
            opcode_q   <= 16'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            result_q   <= 16'd0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            shadow_q   <= shadow_d;
            divert_q   <= divert_d;
            tg_force_q <= tg_force_d;
            opcode_q   <= opcode_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            result_q   <= result_d;
        end
    end

    assign divert_code_bus = divert_q;
    assign tg_force        = tg_force_q;
    assign force_opcode    = opcode_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign err             = err_q;
    assign result          = result_q;

endmodule

// File: tb/tb_dbg_peek_sequencer.sv
// Bench for dbg_peek_sequencer: three parameterisations driven by a cycle-level phase model.
module tb_dbg_peek_sequencer;

    logic        clk;
    logic        reset_n;
    logic        req_a, req_b, req_c;
    logic [3:0]  reg_sel;
    logic        tg_halted;
    logic [15:0] exr_shadow;
    logic [15:0] peek_data;

    logic        o_dv  [3];
    logic [2:0]  o_tf  [3];
    logic [15:0] o_op  [3];
    logic        o_bz  [3];
    logic        o_dn  [3];
    logic        o_er  [3];
    logic [15:0] o_res [3];

    logic [15:0] model_res [3];
    int errs;
    int checks;

    dbg_peek_sequencer u_def (
        .clk(clk), .reset_n(reset_n), .req(req_a), .reg_sel(reg_sel),
        .tg_halted(tg_halted), .exr_shadow(exr_shadow), .peek_data(peek_data),
        .divert_code_bus(o_dv[0]), .tg_force(o_tf[0]), .force_opcode(o_op[0]),
        .busy(o_bz[0]), .done(o_dn[0]), .err(o_er[0]), .result(o_res[0])
    );

    dbg_peek_sequencer #(.SETTLE_CYCLES(1), .CAPTURE_DELAY(0)) u_fast (
        .clk(clk), .reset_n(reset_n), .req(req_b), .reg_sel(reg_sel),
        .tg_halted(tg_halted), .exr_shadow(exr_shadow), .peek_data(peek_data),
        .divert_code_bus(o_dv[1]), .tg_force(o_tf[1]), .force_opcode(o_op[1]),
        .busy(o_bz[1]), .done(o_dn[1]), .err(o_er[1]), .result(o_res[1])
    );

    dbg_peek_sequencer #(.SETTLE_CYCLES(15), .CAPTURE_DELAY(15)) u_slow (
        .clk(clk), .reset_n(reset_n), .req(req_c), .reg_sel(reg_sel),
        .tg_halted(tg_halted), .exr_shadow(exr_shadow), .peek_data(peek_data),
        .divert_code_bus(o_dv[2]), .tg_force(o_tf[2]), .force_opcode(o_op[2]),
        .busy(o_bz[2]), .done(o_dn[2]), .err(o_er[2]), .result(o_res[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v);
        case (i)
            0: req_a = v;
            1: req_b = v;
            default: req_c = v;
        endcase
    endtask

    // Ordering invariants on every instance while out of reset.
    always @(negedge clk) begin
        if (reset_n) begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                assert (!(o_tf[k][1] && o_tf[k][2]) && (!o_tf[k][0] || o_dv[k])) else begin
                    errs++;
                    $error("FAIL invariant inst%0d observed tf=%b divert=%b expected no load+exec, hold implies divert",
                           k, o_tf[k], o_dv[k]);
                end
            end
        end
    end

    // Expected outputs for cycle t after the request cycle, derived from the phase lengths.
    task automatic expect_cycle(input int i, input int S, input int M, input int t,
                                input logic [3:0] sel, input logic [15:0] sh,
                                input logic [15:0] pd, input logic [15:0] prev);
        int L;
        logic edv, ebz, edn, opchk;
        logic [2:0] etf;
        logic [15:0] eop, eres;
        L = 4*S + M + 2;
        edv = 1'b0; etf = 3'b000; eop = 16'h0000; opchk = 1'b1; ebz = 1'b1; edn = 1'b0;
        if (t <= S) begin
            edv = 1'b1; etf = 3'b001; opchk = 1'b0;
        end else if (t <= 2*S) begin
            edv = 1'b1; etf = 3'b011; eop = 16'h7c00 | {12'h000, sel};
        end else if (t <= 3*S) begin
            edv = 1'b1; etf = 3'b101; eop = 16'h7c00 | {12'h000, sel};
        end else if (t <= 3*S + M) begin
            edv = 1'b1; etf = 3'b001; opchk = 1'b0;
        end else if (t <= 4*S + M) begin
            edv = 1'b1; etf = 3'b011; eop = sh;
        end else if (t == L - 1) begin
            edv = 1'b1; opchk = 1'b0;
        end else if (t == L) begin
            edn = 1'b1;
        end else begin
            ebz = 1'b0;
        end
        eres = (t > 3*S + M) ? pd : prev;
        chk($sformatf("i%0d t%0d divert", i, t), 32'(o_dv[i]), 32'(edv));
        chk($sformatf("i%0d t%0d tg_force", i, t), 32'(o_tf[i]), 32'(etf));
        if (opchk) chk($sformatf("i%0d t%0d force_opcode", i, t), 32'(o_op[i]), 32'(eop));
        chk($sformatf("i%0d t%0d busy", i, t), 32'(o_bz[i]), 32'(ebz));
        chk($sformatf("i%0d t%0d done", i, t), 32'(o_dn[i]), 32'(edn));
        chk($sformatf("i%0d t%0d err", i, t), 32'(o_er[i]), 32'd0);
        chk($sformatf("i%0d t%0d result", i, t), 32'(o_res[i]), 32'(eres));
    endtask

    // One full request; peek_data carries pd only in the cycle the sample must happen.
    task automatic run_txn(input int i, input int S, input int C, input logic [3:0] sel,
                           input logic [15:0] sh, input logic [15:0] pd,
                           input bit disturb, input int tail);
        int M, L, ts;
        M  = (C == 0) ? 1 : C;
        L  = 4*S + M + 2;
        ts = 3*S + M;
        @(posedge clk); #1;
        set_req(i, 1'b1);
        reg_sel    = sel;
        exr_shadow = sh;
        tg_halted  = 1'b1;
        peek_data  = ~pd;
        for (int t = 1; t <= L + tail; t++) begin
            @(posedge clk); #1;
            set_req(i, 1'b0);
            peek_data = (t == ts) ? pd : (pd ^ 16'h5a5a ^ 16'(t));
            if (disturb && t == 2*S + 1) begin
                set_req(i, 1'b1);
                exr_shadow = 16'hffff;
                tg_halted  = 1'b0;
            end
            if (disturb && t == L) begin
                set_req(i, 1'b1);
                tg_halted = 1'b1;
            end
            @(negedge clk);
            expect_cycle(i, S, M, t, sel, sh, pd, model_res[i]);
        end
        tg_halted    = 1'b1;
        model_res[i] = pd;
    endtask

    initial begin
        errs = 0;
        checks = 0;
        reset_n = 1'b0;
        req_a = 1'b0; req_b = 1'b0; req_c = 1'b0;
        reg_sel = 4'd0; tg_halted = 1'b0; exr_shadow = 16'd0; peek_data = 16'd0;
        for (int k = 0; k < 3; k++) model_res[k] = 16'd0;

        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset i%0d outputs", k),
                {o_dv[k], o_tf[k], o_bz[k], o_dn[k], o_er[k], o_op[k]}, 32'd0);
            chk($sformatf("reset i%0d result", k), 32'(o_res[k]), 32'd0);
        end
        reset_n = 1'b1;

        // Basic peek with defaults
        run_txn(0, 2, 1, 4'd7, 16'h1234, 16'hbeef, 1'b0, 3);

        // Request while target not halted
        @(posedge clk); #1;
        tg_halted = 1'b0;
        req_a = 1'b1;
        @(posedge clk); #1;
        req_a = 1'b0;
        @(negedge clk);
        chk("nothalt err pulse", 32'(o_er[0]), 32'd1);
        chk("nothalt busy", 32'(o_bz[0]), 32'd0);
        chk("nothalt tg_force", 32'(o_tf[0]), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("nothalt err single", 32'(o_er[0]), 32'd0);
        chk("nothalt busy after", 32'(o_bz[0]), 32'd0);
        chk("nothalt result held", 32'(o_res[0]), 32'(model_res[0]));
        tg_halted = 1'b1;

        // Every register index back to back
        for (int n = 0; n < 16; n++) begin
            run_txn(0, 2, 1, 4'(n), 16'($urandom), 16'h0100 + 16'(n), 1'b0, 1);
        end

        // req, tg_halted and exr_shadow disturbed mid-sequence, plus req coincident with done
        run_txn(0, 2, 1, 4'd9, 16'h1234, 16'($urandom), 1'b1, 3);

        // Asynchronous reset during EXEC
        @(posedge clk); #1;
        req_a = 1'b1; reg_sel = 4'd3; exr_shadow = 16'h1234; tg_halted = 1'b1;
        for (int t = 1; t <= 5; t++) begin
            @(posedge clk); #1;
            req_a = 1'b0;
        end
        chk("areset pre exec tg_force", 32'(o_tf[0]), 32'h5);
        #2;
        reset_n = 1'b0;
        #1;
        chk("areset divert", 32'(o_dv[0]), 32'd0);
        chk("areset tg_force", 32'(o_tf[0]), 32'd0);
        chk("areset busy", 32'(o_bz[0]), 32'd0);
        chk("areset force_opcode", 32'(o_op[0]), 32'd0);
        chk("areset result", 32'(o_res[0]), 32'd0);
        for (int k = 0; k < 3; k++) model_res[k] = 16'd0;
        #10;
        reset_n = 1'b1;
        run_txn(0, 2, 1, 4'd12, 16'($urandom), 16'($urandom), 1'b0, 2);

        // Parameter sweep
        run_txn(1, 1, 0, 4'd5, 16'($urandom), 16'($urandom), 1'b0, 2);
        run_txn(1, 1, 0, 4'd14, 16'($urandom), 16'($urandom), 1'b1, 2);
        run_txn(2, 15, 15, 4'd10, 16'($urandom), 16'($urandom), 1'b0, 2);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/dbg_peek_sequencer.md
Name: dbg_peek_sequencer

Overview:
- Hardware sequencer for the supervisor's register-observe procedure on a halted target.
- Automates the visor firmware steps in fixed order:
  - divert the code bus and hold target state;
  - force-load `debug_peek_reg = rN` into target exr and execute it;
  - capture peek data;
  - refill exr from the shadow and release the target.
- Sits between the visor MCU register file and the target debug port (`bus_ctrl` / `tg_force` / `force_opcode`). Firmware issues one request instead of hand-sequencing six writes.

Parameters:
- PEEK_OPCODE_BASE, 16'h7c00, opcode of `debug_peek_reg = r0`; the register index is ORed into bits [3:0].
- SETTLE_CYCLES, 2, cycles each forced step is held (1..15).
- CAPTURE_DELAY, 1, cycles after exec deassert before `peek_data` is sampled (0..15).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- req  in  1  start pulse; sampled only in IDLE
- reg_sel  in  4  target register index to observe
- tg_halted  in  1  target stopped at breakpoint (bp_status nonzero)
- exr_shadow  in  16  target's pending exr value
- peek_data  in  16  target debug_peek_reg output
- divert_code_bus  out  1  drives the `bus_ctrl` divert bit
- tg_force  out  3  {force_exec, force_load_exr, hold_state}
- force_opcode  out  16  opcode presented to target exr
- busy  out  1  high from acceptance through RELEASE
- done  out  1  one-cycle pulse; result valid
- err  out  1  one-cycle pulse; request rejected (target not halted)
- result  out  16  captured register value; holds until next done

Behaviour:
- Reset values: all outputs 0; state IDLE; internal latches 0. Reset is asynchronous and may assert mid-sequence; outputs drop to 0 immediately, releasing the target.
- All outputs are registered.
- Accepting a request in IDLE:
  - req=1 and tg_halted=1: latch reg_sel and exr_shadow, go to DIVERT.
  - req=1 and tg_halted=0: err=1 for the next cycle, stay in IDLE.
- req while busy: ignored. It is not queued and raises no err.
- States and outputs:
  - DIVERT: divert=1, tg_force=3'b001. Held SETTLE_CYCLES cycles, then LOAD_PEEK.
  - LOAD_PEEK: force_opcode = PEEK_OPCODE_BASE | reg_sel_latched, tg_force=3'b011. Held SETTLE_CYCLES, then EXEC.
  - EXEC: tg_force=3'b101, force_opcode unchanged. Held SETTLE_CYCLES, then CAPTURE.
  - CAPTURE: tg_force=3'b001. Wait CAPTURE_DELAY cycles, sample peek_data into result on the last cycle, then RESTORE.
  - RESTORE: force_opcode = exr_shadow_latched, tg_force=3'b011. Held SETTLE_CYCLES, then UNHOLD.
  - UNHOLD: tg_force=0, divert still 1. One cycle, then RELEASE.
  - RELEASE: divert=0, force_opcode=0. done=1 this cycle, busy=0 next cycle, then IDLE.
- Step counter is 4 bits. Loaded with (count−1) on state entry and decremented; advance occurs when it reaches 0.
  - CAPTURE_DELAY=0: sample on the CAPTURE entry cycle.
- Total latency, req to done: 4·SETTLE_CYCLES + max(CAPTURE_DELAY,1) + 2 cycles. Defaults: 11 cycles.
- Ordering guarantees:
  - divert asserts no later than hold_state.
  - load_exr and exec are never both 1.
  - exr is always restored before hold is released.
- tg_halted falling mid-sequence: ignored; the sequence completes. Firmware owns breakpoint re-arm.
- exr_shadow changing after acceptance: no effect (value was latched).
- Simultaneous req and done: req is ignored, since the block is not in IDLE.

Decomposition:
- Package visor_dbg_pkg contains:
  - state enum: IDLE, DIVERT, LOAD_PEEK, EXEC, CAPTURE, RESTORE, UNHOLD, RELEASE;
  - mask constants HOLD_STATE_MASK=1, FORCE_LOAD_EXR_MASK=2, FORCE_EXEC_MASK=4, DIVERT_CODE_BUS_MASK=4, TG_RESET_MASK=2;
  - PEEK_OPCODE_BASE default.
- One sub-module, dbg_step_timer: loadable 4-bit down counter with `zero` flag. The FSM and output registers stay in dbg_peek_sequencer.

Test Plan:
- Basic peek, defaults: tg_halted=1, reg_sel=7, exr_shadow=16'h1234, peek_data=16'hbeef → force_opcode 16'h7c07 during LOAD_PEEK; result=16'hbeef; done pulse exactly 11 cycles after req; force_opcode 16'h1234 during RESTORE; all outputs 0 after RELEASE.
- Not halted: req with tg_halted=0 → single-cycle err, busy stays 0, tg_force stays 0.
- Exhaustive reg_sel: 0..15 back-to-back, with peek_data = 16'h0100+N driven during CAPTURE → opcodes 16'h7c00..7c0f, results match. Assertions hold throughout: load_exr and exec never both high; divert=1 whenever hold=1.
- Busy and mid-sequence changes: req pulses during EXEC, and exr_shadow changed to 16'hffff mid-sequence → ignored; RESTORE still drives the originally latched 16'h1234; only one done.
- Async reset mid-sequence: reset_n low during EXEC (off clock edge) → divert, tg_force and busy go to 0 immediately; after release the block returns to IDLE and accepts a new req normally.
- Parameter sweep: SETTLE_CYCLES=1 with CAPTURE_DELAY=0, and SETTLE_CYCLES=15 with CAPTURE_DELAY=15 → latencies of 7 and 77 cycles; result sampled on the correct cycle.
